// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and
// instruction memory. Signal names keep the fetch unit's point of view:
// O_* are driven by the fetch unit and I_* are driven by the memory.
interface fetch_unit_if #(
  parameter int unsigned PC_WIDTH = 16
);
  logic                O_mem_req;   // request, held until acknowledged
  logic [PC_WIDTH-1:0] O_mem_addr;  // word address, equals the fetch pc
  logic                I_mem_ack;   // data valid this cycle
  logic [15:0]         I_mem_data;  // instruction word

  // The fetch unit issues requests.
  modport master (
    output O_mem_req,
    output O_mem_addr,
    input  I_mem_ack,
    input  I_mem_data
  );

  // The instruction memory answers them.
  modport slave (
    input  O_mem_req,
    input  O_mem_addr,
    output I_mem_ack,
    output I_mem_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the decoder. Keeps the program counter,
// fetches one 16-bit word at a time over a req/ack bus, buffers at most one
// instruction for the decoder and handles stall and branch redirect/flush.
// All outputs come straight from registers.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                I_clk,
  input  logic                I_reset_n,
  input  logic                I_enable,
  input  logic                I_stall,
  input  logic                I_branch,
  input  logic [PC_WIDTH-1:0] I_branch_target,
  fetch_unit_if.master        mem,
  output logic [15:0]         O_instruction,
  output logic                O_valid,
  output logic [PC_WIDTH-1:0] O_pc
);

  // IDLE : nothing outstanding, nothing buffered
  // FETCH: request outstanding, the answer will be delivered
  // HOLD : instruction buffered for the decoder, no request
  // FLUSH: request outstanding for a stale address, answer is dropped
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                req_q;
  logic [15:0]         instr_q;
  logic                valid_q;
  logic [PC_WIDTH-1:0] opc_q;

  // The memory address is the pc itself, so it only moves on an
  // acknowledge or on a branch redirect.
  assign mem.O_mem_req  = req_q;
  assign mem.O_mem_addr = pc_q;
  assign O_instruction  = instr_q;
  assign O_valid        = valid_q;
  assign O_pc           = opc_q;

  // Fetch FSM with its registered outputs; branch outranks everything but reset.
  // NOTE: asynchronous reset lives in the sensitivity list, and every state
  // register uses non-blocking assignment so all of them see the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
      opc_q   <= '0;
    end else if (I_branch) begin
      // Redirect: any buffered instruction is dropped unconsumed.
      pc_q    <= I_branch_target;
      valid_q <= 1'b0;
      case (state_q)
        IDLE, HOLD: begin
          state_q <= I_enable ? FETCH : IDLE;
          req_q   <= I_enable;
        end
        FETCH: begin
          // With an ack this cycle the old request is complete and its data
          // is dropped; the new address is a fresh request. Without one the
          // old request is still in flight, so its answer must be discarded.
          state_q <= mem.I_mem_ack ? FETCH : FLUSH;
          req_q   <= 1'b1;
        end
        FLUSH: begin
          state_q <= FLUSH;
          req_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (I_enable) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        FETCH: begin
          // A fetch in flight completes even if I_enable has dropped.
          if (mem.I_mem_ack) begin
            instr_q <= mem.I_mem_data;
            opc_q   <= pc_q;
            valid_q <= 1'b1;
            pc_q    <= pc_q + PC_WIDTH'(1);
            req_q   <= 1'b0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // Consumed when the decoder is not stalling.
          if (!I_stall) begin
            valid_q <= 1'b0;
            state_q <= I_enable ? FETCH : IDLE;
            req_q   <= I_enable;
          end
        end
        FLUSH: begin
          // Stale answer arrives: drop it and refetch at pc unchanged.
          if (mem.I_mem_ack) begin
            state_q <= I_enable ? FETCH : IDLE;
            req_q   <= I_enable;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
